marine_radar_settings_bank: RTL and testbench



---
 rtl/marine_radar_ctrl_pkg.sv | 21 ++
 rtl/marine_radar_settings_bank_setting_cell.sv | 85 ++++++++
 rtl/marine_radar_settings_bank.sv | 168 ++++++++++++++++
 tb/tb_marine_radar_settings_bank.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/marine_radar_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// marine_radar_ctrl_pkg
// Shared definitions for the marine radar settings bank.
//   - Control-register bit positions (ARM, NOW, ABORT, SRST).
//   - Control-register placement: the control register sits CTRL offset words
//     above BASE_ADDR, where the offset equals the number of data registers.
// Optional feature macro used by the bank: MARINE_RADAR_READBACK_EN.
// -----------------------------------------------------------------------------
package marine_radar_ctrl_pkg;

    localparam int CTRL_ARM   = 0;
    localparam int CTRL_NOW   = 1;
    localparam int CTRL_ABORT = 2;
    localparam int CTRL_SRST  = 3;

    // The control register always follows the last data register.
    function automatic int ctrl_offset(input int num_regs);
        return num_regs;
    endfunction

endpackage

// File: rtl/marine_radar_settings_bank_setting_cell.sv
// -----------------------------------------------------------------------------
// setting_cell
// One shadow/active/dirty slice of the settings bank.
//   IMMEDIATE=1 : writes load shadow and active together, dirty never set.
//   IMMEDIATE=0 : writes load shadow and set dirty; active loads on commit.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   clear            synchronous hold-at-zero (soft reset); suppresses changed
//   wr_en, wr_data   accepted data write to this register
//   commit           commit edge: active <= shadow if dirty
//   abort            shadow <= active, dirty cleared
//   active_q         current active value
//   changed_q        one-cycle pulse after active was loaded
//   dirty_q          shadow holds an uncommitted value
//   shadow_q         shadow value (only with MARINE_RADAR_READBACK_EN)
// -----------------------------------------------------------------------------
module setting_cell
    import marine_radar_ctrl_pkg::*;
#(
    parameter bit IMMEDIATE = 1'b0,
    parameter int DATA_W    = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              commit,
    input  logic              abort,
    output logic [DATA_W-1:0] active_q,
    output logic              changed_q,
`ifdef MARINE_RADAR_READBACK_EN
    output logic [DATA_W-1:0] shadow_q,
`endif
    output logic              dirty_q
);

    logic [DATA_W-1:0] shadow;

`ifdef MARINE_RADAR_READBACK_EN
    assign shadow_q = shadow;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow    <= '0;
            active_q  <= '0;
            dirty_q   <= 1'b0;
            changed_q <= 1'b0;
        end else if (clear) begin
            shadow    <= '0;
            active_q  <= '0;
            dirty_q   <= 1'b0;
            changed_q <= 1'b0;
        end else begin
            changed_q <= 1'b0;
            if (IMMEDIATE) begin
                if (wr_en) begin
                    shadow    <= wr_data;
                    active_q  <= wr_data;
                    changed_q <= 1'b1;
                end else if (abort) begin
                    shadow <= active_q;
                end
            end else begin
                // Commit uses the shadow as it was before this edge, so a write
                // landing on the commit edge stays pending for the next commit.
                if (commit && dirty_q) begin
                    active_q  <= shadow;
                    changed_q <= 1'b1;
                end
                if (abort) begin
                    shadow  <= active_q;
                    dirty_q <= 1'b0;
                end else if (wr_en) begin
                    shadow  <= wr_data;
                    dirty_q <= 1'b1;
                end else if (commit) begin
                    dirty_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/marine_radar_settings_bank.sv
// -----------------------------------------------------------------------------
// marine_radar_settings_bank
// Double-buffered radar setting registers on the serial settings bus.
// Deferred registers commit atomically on sweep_sync (when armed) or on a NOW
// command; immediate registers (IMMEDIATE_MASK) bypass the shadow. Also
// generates a stretched active-high soft reset for the DSP chain.
// Ports:
//   master_clk, reset_n          clock, asynchronous active-low reset
//   serial_addr/data/strobe      settings bus write
//   sweep_sync                   sweep boundary pulse
//   regs_flat                    active values, reg i at [i*DATA_W +: DATA_W]
//   changed                      per-register pulse after active load
//   commit_pending               any register dirty
//   armed                        commit waiting for sweep_sync
//   soft_reset                   stretched DSP reset
//   write_err                    pulse on discarded or tearing-hazard write
//   rd_addr, rd_shadow, rd_data  registered readback (MARINE_RADAR_READBACK_EN)
// -----------------------------------------------------------------------------
module marine_radar_settings_bank
    import marine_radar_ctrl_pkg::*;
#(
    parameter int                NUM_REGS       = 16,
    parameter int                DATA_W         = 32,
    parameter int                ADDR_W         = 7,
    parameter logic [ADDR_W-1:0] BASE_ADDR      = 7'd64,
    parameter logic [31:0]       IMMEDIATE_MASK = 32'h0000_0001,
    parameter int                RST_STRETCH    = 8
) (
    input  logic                       master_clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          serial_addr,
    input  logic [31:0]                serial_data,
    input  logic                       serial_strobe,
    input  logic                       sweep_sync,
`ifdef MARINE_RADAR_READBACK_EN
    input  logic [ADDR_W-1:0]          rd_addr,
    input  logic                       rd_shadow,
    output logic [31:0]                rd_data,
`endif
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [NUM_REGS-1:0]        changed,
    output logic                       commit_pending,
    output logic                       armed,
    output logic                       soft_reset,
    output logic                       write_err
);

    localparam int CTRL_ADDR = int'(BASE_ADDR) + ctrl_offset(NUM_REGS);
    localparam int CNT_W     = $clog2(RST_STRETCH + 1);

    logic [NUM_REGS-1:0] data_hit;
    logic [NUM_REGS-1:0] dirty;
    logic [NUM_REGS-1:0] deferred_mask;
    logic                ctrl_hit;
    logic                ctrl_wr;
    logic                srst_load;
    logic                clear;
    logic                abort;
    logic                commit;
    logic                now_req;
    logic                err_next;
    logic [CNT_W-1:0]    stretch_cnt;

`ifdef MARINE_RADAR_READBACK_EN
    logic [NUM_REGS*DATA_W-1:0] shadow_flat;
`endif

    assign deferred_mask = ~IMMEDIATE_MASK[NUM_REGS-1:0];
    assign ctrl_hit      = serial_strobe && (int'(serial_addr) == CTRL_ADDR);
    assign ctrl_wr       = ctrl_hit && !soft_reset;
    // SRST is honoured even while counting so that it can reload the stretch.
    assign srst_load     = ctrl_hit && serial_data[CTRL_SRST];
    // Registers are zeroed on the SRST edge itself and for the whole stretch.
    assign clear         = soft_reset || srst_load;
    assign abort         = ctrl_wr && serial_data[CTRL_ABORT] && !clear;
    // ABORT on a would-be commit edge discards the pending values instead.
    assign commit        = (now_req || (armed && sweep_sync)) && !abort && !clear;
    assign soft_reset    = (stretch_cnt != '0);
    assign commit_pending = |dirty;

    // Discarded strobes during soft reset, or a deferred write while armed.
    assign err_next = soft_reset
                    ? ((|data_hit) || (ctrl_hit && !serial_data[CTRL_SRST]))
                    : ((|(data_hit & deferred_mask)) && armed);

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_cell
        assign data_hit[i] = serial_strobe && (int'(serial_addr) == int'(BASE_ADDR) + i);

        setting_cell #(
            .IMMEDIATE (IMMEDIATE_MASK[i]),
            .DATA_W    (DATA_W)
        ) u_cell (
            .clk       (master_clk),
            .reset_n   (reset_n),
            .clear     (clear),
            .wr_en     (data_hit[i] && !soft_reset),
            .wr_data   (serial_data[DATA_W-1:0]),
            .commit    (commit),
            .abort     (abort),
            .active_q  (regs_flat[i*DATA_W +: DATA_W]),
            .changed_q (changed[i]),
`ifdef MARINE_RADAR_READBACK_EN
            .shadow_q  (shadow_flat[i*DATA_W +: DATA_W]),
`endif
            .dirty_q   (dirty[i])
        );
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            armed       <= 1'b0;
            now_req     <= 1'b0;
            write_err   <= 1'b0;
            stretch_cnt <= '0;
        end else begin
            write_err <= err_next;

            if (srst_load) begin
                stretch_cnt <= CNT_W'(RST_STRETCH);
            end else if (soft_reset) begin
                stretch_cnt <= stretch_cnt - CNT_W'(1);
            end

            // A fresh ARM/NOW on the commit edge re-arms for the next commit.
            if (clear || abort) begin
                armed   <= 1'b0;
                now_req <= 1'b0;
            end else begin
                if (ctrl_wr && serial_data[CTRL_ARM]) begin
                    armed <= 1'b1;
                end else if (commit) begin
                    armed <= 1'b0;
                end
                if (ctrl_wr && serial_data[CTRL_NOW]) begin
                    now_req <= 1'b1;
                end else if (commit) begin
                    now_req <= 1'b0;
                end
            end
        end
    end

`ifdef MARINE_RADAR_READBACK_EN
    logic [31:0] rd_next;

    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (int'(rd_addr) == int'(BASE_ADDR) + i) begin
                rd_next[DATA_W-1:0] = rd_shadow ? shadow_flat[i*DATA_W +: DATA_W]
                                                : regs_flat[i*DATA_W +: DATA_W];
            end
        end
        if (int'(rd_addr) == CTRL_ADDR) begin
            rd_next = {27'b0, commit_pending, soft_reset, 2'b0, armed};
        end
    end

    always_ff @(posedge master_clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= rd_next;
        end
    end
`endif

endmodule

// File: tb/tb_marine_radar_settings_bank.sv
// -----------------------------------------------------------------------------
// tb_marine_radar_settings_bank
// Directed bench for marine_radar_settings_bank with default parameters
// (16 x 32-bit registers, base 64, control at 80, reg0 immediate, stretch 8).
// Inputs change on the falling edge; outputs are sampled on the falling edge
// after the rising edge that consumed them.
// -----------------------------------------------------------------------------
module tb_marine_radar_settings_bank;

    localparam int NUM_REGS = 16;
    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 7;
    localparam int BASE     = 64;
    localparam int CTRL     = 80;

    // ---------------- clock / reset ----------------
    logic master_clk = 1'b0;
    logic reset_n    = 1'b0;
    always #5 master_clk = ~master_clk;

    logic [ADDR_W-1:0]          serial_addr   = '0;
    logic [31:0]                serial_data   = '0;
    logic                       serial_strobe = 1'b0;
    logic                       sweep_sync    = 1'b0;
    logic [NUM_REGS*DATA_W-1:0] regs_flat;
    logic [NUM_REGS-1:0]        changed;
    logic                       commit_pending;
    logic                       armed;
    logic                       soft_reset;
    logic                       write_err;
`ifdef MARINE_RADAR_READBACK_EN
    logic [ADDR_W-1:0]          rd_addr   = '0;
    logic                       rd_shadow = 1'b0;
    logic [31:0]                rd_data;
`endif

    marine_radar_settings_bank dut (
        .master_clk     (master_clk),
        .reset_n        (reset_n),
        .serial_addr    (serial_addr),
        .serial_data    (serial_data),
        .serial_strobe  (serial_strobe),
        .sweep_sync     (sweep_sync),
`ifdef MARINE_RADAR_READBACK_EN
        .rd_addr        (rd_addr),
        .rd_shadow      (rd_shadow),
        .rd_data        (rd_data),
`endif
        .regs_flat      (regs_flat),
        .changed        (changed),
        .commit_pending (commit_pending),
        .armed          (armed),
        .soft_reset     (soft_reset),
        .write_err      (write_err)
    );

    // ---------------- scoreboard / checking ----------------
    int n_checks = 0;
    int n_fail   = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] reg_val(input int i);
        return regs_flat[i*DATA_W +: DATA_W];
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge master_clk);
    endtask

    task automatic bus_write(input int addr, input logic [31:0] data);
        serial_addr   = ADDR_W'(addr);
        serial_data   = data;
        serial_strobe = 1'b1;
        @(negedge master_clk);
        serial_strobe = 1'b0;
    endtask

    task automatic sweep_pulse();
        sweep_sync = 1'b1;
        @(negedge master_clk);
        sweep_sync = 1'b0;
    endtask

    // Safety net: the sequence is fixed-length, but never let it hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int sr_cycles;
        int err_pulses;
        logic [NUM_REGS-1:0] chg_seen;

        // ---- reset ----
        tick(3);
        check("rst_regs_zero", {31'b0, |regs_flat}, 32'd0);
        check("rst_changed", {16'b0, changed}, 32'd0);
        check("rst_pending", {31'b0, commit_pending}, 32'd0);
        check("rst_armed", {31'b0, armed}, 32'd0);
        check("rst_soft_reset", {31'b0, soft_reset}, 32'd0);
        check("rst_write_err", {31'b0, write_err}, 32'd0);
        reset_n = 1'b1;
        tick(1);

        // ---- immediate register 0 ----
        bus_write(BASE + 0, 32'h1234);
        check("imm_reg0", reg_val(0), 32'h1234);
        check("imm_changed", {16'b0, changed}, 32'h0001);
        check("imm_pending", {31'b0, commit_pending}, 32'd0);
        tick(1);
        check("imm_changed_drop", {16'b0, changed}, 32'd0);

        // ---- deferred reg3 committed at sweep ----
        bus_write(BASE + 3, 32'hAA);
        check("def_reg3_held", reg_val(3), 32'd0);
        check("def_pending", {31'b0, commit_pending}, 32'd1);
        check("def_no_changed", {16'b0, changed}, 32'd0);
        bus_write(CTRL, 32'h1);
        check("arm_set", {31'b0, armed}, 32'd1);
        tick(9);
        check("def_reg3_wait", reg_val(3), 32'd0);
        sweep_pulse();
        check("sweep_reg3", reg_val(3), 32'hAA);
        check("sweep_changed3", {16'b0, changed}, 32'h0008);
        check("sweep_armed_drop", {31'b0, armed}, 32'd0);
        check("sweep_pending_drop", {31'b0, commit_pending}, 32'd0);
        tick(1);
        check("sweep_changed_drop", {16'b0, changed}, 32'd0);

        // ---- ARM coincident with sweep_sync, tearing warning ----
        bus_write(BASE + 4, 32'h55);
        serial_addr   = ADDR_W'(CTRL);
        serial_data   = 32'h1;
        serial_strobe = 1'b1;
        sweep_sync    = 1'b1;
        @(negedge master_clk);
        serial_strobe = 1'b0;
        sweep_sync    = 1'b0;
        check("armsweep_no_commit", reg_val(4), 32'd0);
        check("armsweep_armed", {31'b0, armed}, 32'd1);
        bus_write(BASE + 6, 32'h66);
        check("tear_write_err", {31'b0, write_err}, 32'd1);
        tick(1);
        check("tear_err_drop", {31'b0, write_err}, 32'd0);
        tick(2);
        sweep_pulse();
        check("armsweep_reg4", reg_val(4), 32'h55);
        check("armsweep_reg6", reg_val(6), 32'h66);
        check("armsweep_changed", {16'b0, changed}, 32'h0050);

        // ---- NOW with write on the commit edge ----
        bus_write(BASE + 5, 32'h1);
        bus_write(CTRL, 32'h2);
        check("now_latency_hold", reg_val(5), 32'd0);
        bus_write(BASE + 5, 32'h2);
        check("now_old_shadow", reg_val(5), 32'h1);
        check("now_changed5", {16'b0, changed}, 32'h0020);
        check("now_still_pending", {31'b0, commit_pending}, 32'd1);
        check("now_no_err", {31'b0, write_err}, 32'd0);
        bus_write(CTRL, 32'h2);
        tick(1);
        check("now_second_commit", reg_val(5), 32'h2);
        check("now_pending_clear", {31'b0, commit_pending}, 32'd0);

        // ---- ABORT beats ARM ----
        bus_write(BASE + 2, 32'h7);
        bus_write(CTRL, 32'h1);
        bus_write(CTRL, 32'h5);
        check("abort_armed", {31'b0, armed}, 32'd0);
        check("abort_pending", {31'b0, commit_pending}, 32'd0);
        sweep_pulse();
        check("abort_reg2", reg_val(2), 32'd0);
        check("abort_no_changed", {16'b0, changed}, 32'd0);
        bus_write(CTRL, 32'h2);
        tick(1);
        check("abort_shadow_restored", reg_val(2), 32'd0);

        // ---- out-of-range writes ignored ----
        bus_write(CTRL + 1, 32'hDEAD);
        check("oor_hi_err", {31'b0, write_err}, 32'd0);
        bus_write(10, 32'hBEEF);
        check("oor_lo_err", {31'b0, write_err}, 32'd0);
        check("oor_reg0", reg_val(0), 32'h1234);
        check("oor_pending", {31'b0, commit_pending}, 32'd0);

        // ---- soft reset stretch ----
        sr_cycles  = 0;
        err_pulses = 0;
        chg_seen   = '0;
        serial_addr   = ADDR_W'(CTRL);
        serial_data   = 32'h8;
        serial_strobe = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge master_clk);
            serial_strobe = 1'b0;
            if (k == 2) begin
                serial_addr   = ADDR_W'(BASE);
                serial_data   = 32'h99;
                serial_strobe = 1'b1;
            end
            if (soft_reset) sr_cycles++;
            if (write_err) err_pulses++;
            chg_seen |= changed;
            if (k == 1) check("srst_regs_zero", {31'b0, |regs_flat}, 32'd0);
        end
        check("srst_high_cycles", 32'(sr_cycles), 32'd8);
        check("srst_err_pulses", 32'(err_pulses), 32'd1);
        check("srst_no_changed", {16'b0, chg_seen}, 32'd0);
        check("srst_regs_after", {31'b0, |regs_flat}, 32'd0);
        check("srst_armed", {31'b0, armed}, 32'd0);
        bus_write(BASE + 0, 32'h77);
        check("post_srst_write", reg_val(0), 32'h77);

        // ---- report ----
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
